// File: rtl/c_ext_pkg.sv
// -----------------------------------------------------------------------------
// c_ext_pkg
// Shared definitions for the compressed-extension (RVC) fetch logic in the IF
// stage: the spanning-instruction state encoding and the parcel width.
// -----------------------------------------------------------------------------
package c_ext_pkg;

   // States of the machine that rebuilds a 32-bit instruction whose low half
   // sits in the upper parcel of one fetch word and whose high half sits in the
   // lower parcel of the next.
   typedef enum logic [1:0] {
      SPAN_IDLE    = 2'd0,
      SPAN_WAIT    = 2'd1,
      SPAN_READY   = 2'd2,
      SPAN_HOLDOFF = 2'd3
   } span_state_e;

   // One RVC parcel (a halfword).
   localparam int PARCEL_W = 16;

endpackage

// File: rtl/c_ext_fetch_state.sv
// -----------------------------------------------------------------------------
// c_ext_fetch_state
// Sequential companion to the IF-stage instruction aligner. It registers every
// piece of compressed-extension fetch state the aligner consumes on the next
// cycle: the buffered instruction word, compressed-at-lo tracking and its
// stall-saved copy, and the spanning-instruction state machine.
//
// Configuration macro:
//   FROST_SPAN_HOLDOFF_EN - when defined, a SPAN_HOLDOFF state adds one NOP
//                           cycle after a spanning instruction (for memories
//                           whose halfword redirect returns stale data). When
//                           undefined, o_spanning_to_halfword_registered is 0.
//
// Ports:
//   i_clk, i_rst                        clock, synchronous active-high reset
//   i_stall, i_flush                    hold IF stage / clear fetch state
//   i_pc_reg                            registered PC of the current cycle
//   i_instr                             raw memory word
//   i_effective_instr                   aligner-selected word
//   i_is_compressed, i_sel_nop          aligner per-cycle decisions
//   o_instr_buffer                      buffered instruction word
//   o_prev_was_compressed_at_lo(_saved) compressed-at-lo flag and stall copy
//   o_stall_registered                  i_stall delayed one cycle
//   o_spanning_wait_for_fetch           state is SPAN_WAIT
//   o_spanning_in_progress              state is SPAN_READY
//   o_spanning_buffer/_second_half      low / high halves of spanning instr
//   o_spanning_to_halfword_registered   state is SPAN_HOLDOFF
//   o_use_buffer_after_spanning         read buffer after a spanning instr
// -----------------------------------------------------------------------------
module c_ext_fetch_state
   import c_ext_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_stall,
   input  logic                i_flush,
   input  logic [XLEN-1:0]     i_pc_reg,
   input  logic [XLEN-1:0]     i_instr,
   input  logic [XLEN-1:0]     i_effective_instr,
   input  logic                i_is_compressed,
   input  logic                i_sel_nop,
   output logic [XLEN-1:0]     o_instr_buffer,
   output logic                o_prev_was_compressed_at_lo,
   output logic                o_prev_was_compressed_at_lo_saved,
   output logic                o_stall_registered,
   output logic                o_spanning_wait_for_fetch,
   output logic                o_spanning_in_progress,
   output logic [PARCEL_W-1:0] o_spanning_buffer,
   output logic [PARCEL_W-1:0] o_spanning_second_half,
   output logic                o_spanning_to_halfword_registered,
   output logic                o_use_buffer_after_spanning
);

   // The spanning state after which the aligner switches to the buffer.
`ifdef FROST_SPAN_HOLDOFF_EN
   localparam span_state_e LAST_SPAN = SPAN_HOLDOFF;
`else
   localparam span_state_e LAST_SPAN = SPAN_READY;
`endif

   span_state_e         state_q, state_d;
   logic [XLEN-1:0]     instr_buffer_q, instr_buffer_d;
   logic                prev_q, prev_d;
   logic                saved_q, saved_d;
   logic                stall_reg_q, stall_reg_d;
   logic                span_wait_q, span_wait_d;
   logic                span_ready_q, span_ready_d;
   logic                span_holdoff_q, span_holdoff_d;
   logic [PARCEL_W-1:0] spanning_buffer_q, spanning_buffer_d;
   logic [PARCEL_W-1:0] second_half_q, second_half_d;
   logic                use_buf_q, use_buf_d;
   logic                compressed_at_lo;

   // Only PC[1] matters here: it tells which parcel of the word is current.
   logic unused_pc;
   assign unused_pc = ^{i_pc_reg[XLEN-1:2], i_pc_reg[0]};

   assign compressed_at_lo = !i_pc_reg[1] && i_is_compressed && !i_sel_nop;

   always_comb begin
      // NOTE: every _d starts at its _q so unassigned paths hold state and
      // no latch is inferred.
      state_d           = state_q;
      instr_buffer_d    = instr_buffer_q;
      prev_d            = prev_q;
      saved_d           = saved_q;
      spanning_buffer_d = spanning_buffer_q;
      second_half_d     = second_half_q;
      use_buf_d         = use_buf_q;
      stall_reg_d       = i_stall;  // tracks stall even through a flush

      if (i_flush) begin
         state_d           = SPAN_IDLE;
         instr_buffer_d    = '0;
         prev_d            = 1'b0;
         saved_d           = 1'b0;
         spanning_buffer_d = '0;
         second_half_d     = '0;
         use_buf_d         = 1'b0;
      end else if (i_stall) begin
         // Snapshot the flag only on the first stalled cycle; later stall
         // cycles keep the pre-stall value.
         if (!stall_reg_q) saved_d = prev_q;
      end else begin
         prev_d    = compressed_at_lo;
         use_buf_d = (state_q == LAST_SPAN);
         if (compressed_at_lo) instr_buffer_d = i_effective_instr;

         unique case (state_q)
            SPAN_IDLE: begin
               if (i_pc_reg[1] && !i_is_compressed) begin
                  state_d           = SPAN_WAIT;
                  spanning_buffer_d = i_effective_instr[XLEN-1 -: PARCEL_W];
               end
            end
            SPAN_WAIT: begin
               // Fresh memory word: take its low parcel as the second half
               // and buffer the whole word (overrides the capture above).
               state_d        = SPAN_READY;
               second_half_d  = i_instr[PARCEL_W-1:0];
               instr_buffer_d = i_instr;
            end
            SPAN_READY: begin
`ifdef FROST_SPAN_HOLDOFF_EN
               state_d = SPAN_HOLDOFF;
`else
               state_d = SPAN_IDLE;
`endif
            end
            default: state_d = SPAN_IDLE;
         endcase
      end

      span_wait_d    = (state_d == SPAN_WAIT);
      span_ready_d   = (state_d == SPAN_READY);
      span_holdoff_d = (state_d == SPAN_HOLDOFF);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q           <= SPAN_IDLE;
         instr_buffer_q    <= '0;
         prev_q            <= 1'b0;
         saved_q           <= 1'b0;
         stall_reg_q       <= 1'b0;
         span_wait_q       <= 1'b0;
         span_ready_q      <= 1'b0;
         span_holdoff_q    <= 1'b0;
         spanning_buffer_q <= '0;
         second_half_q     <= '0;
         use_buf_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         instr_buffer_q    <= instr_buffer_d;
         prev_q            <= prev_d;
         saved_q           <= saved_d;
         stall_reg_q       <= stall_reg_d;
         span_wait_q       <= span_wait_d;
         span_ready_q      <= span_ready_d;
         span_holdoff_q    <= span_holdoff_d;
         spanning_buffer_q <= spanning_buffer_d;
         second_half_q     <= second_half_d;
         use_buf_q         <= use_buf_d;
      end
   end

   assign o_instr_buffer                    = instr_buffer_q;
   assign o_prev_was_compressed_at_lo       = prev_q;
   assign o_prev_was_compressed_at_lo_saved = saved_q;
   assign o_stall_registered                = stall_reg_q;
   assign o_spanning_wait_for_fetch         = span_wait_q;
   assign o_spanning_in_progress            = span_ready_q;
   assign o_spanning_buffer                 = spanning_buffer_q;
   assign o_spanning_second_half            = second_half_q;
   assign o_use_buffer_after_spanning       = use_buf_q;
`ifdef FROST_SPAN_HOLDOFF_EN
   assign o_spanning_to_halfword_registered = span_holdoff_q;
`else
   assign o_spanning_to_halfword_registered = 1'b0;
   logic unused_holdoff;
   assign unused_holdoff = span_holdoff_q;
`endif

endmodule

// File: tb/tb_c_ext_fetch_state.sv
// -----------------------------------------------------------------------------
// tb_c_ext_fetch_state
// Directed bench for c_ext_fetch_state. Inputs change 1 ns after a rising edge
// and outputs are checked 1 ns after the following edge. Expectations for the
// SPAN_HOLDOFF path follow FROST_SPAN_HOLDOFF_EN.
// -----------------------------------------------------------------------------
module tb_c_ext_fetch_state;

   logic        clk = 1'b0;
   logic        rst, stall, flush, comp, nop;
   logic [31:0] pc, instr, eff;

   logic [31:0] o_instr_buffer;
   logic        o_prev, o_saved, o_stall_reg, o_wait, o_inprog, o_holdoff, o_use_buf;
   logic [15:0] o_span_buf, o_second;

   int nchecks = 0;
   int nerrors = 0;

   c_ext_fetch_state #(.XLEN(32)) dut (
      .i_clk                             (clk),
      .i_rst                             (rst),
      .i_stall                           (stall),
      .i_flush                           (flush),
      .i_pc_reg                          (pc),
      .i_instr                           (instr),
      .i_effective_instr                 (eff),
      .i_is_compressed                   (comp),
      .i_sel_nop                         (nop),
      .o_instr_buffer                    (o_instr_buffer),
      .o_prev_was_compressed_at_lo       (o_prev),
      .o_prev_was_compressed_at_lo_saved (o_saved),
      .o_stall_registered                (o_stall_reg),
      .o_spanning_wait_for_fetch         (o_wait),
      .o_spanning_in_progress            (o_inprog),
      .o_spanning_buffer                 (o_span_buf),
      .o_spanning_second_half            (o_second),
      .o_spanning_to_halfword_registered (o_holdoff),
      .o_use_buffer_after_spanning       (o_use_buf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Quiet cycle: compressed parcel at lo but NOP, so nothing is captured.
   task automatic idle_inputs();
      stall = 0; flush = 0; pc = 32'h200; instr = 0; eff = 0; comp = 1; nop = 1;
   endtask

   function automatic logic [70:0] all_outs();
      return {o_instr_buffer, o_prev, o_saved, o_stall_reg, o_wait, o_inprog,
              o_span_buf, o_second, o_holdoff, o_use_buf};
   endfunction

   task automatic test_reset();
      rst = 1; idle_inputs();
      step(); step();
      nchecks++; if (all_outs() !== '0) begin nerrors++; $display("FAIL reset_state: got %h want 0", all_outs()); end
      // Reset arriving in SPAN_WAIT.
      rst = 0; pc = 32'h102; comp = 0; eff = 32'h0513_0000;
      step();
      nchecks++; if (o_wait !== 1'b1) begin nerrors++; $display("FAIL pre_reset_wait: got %b want 1", o_wait); end
      rst = 1; step();
      nchecks++; if (all_outs() !== '0) begin nerrors++; $display("FAIL reset_mid_wait: got %h want 0", all_outs()); end
      rst = 0; idle_inputs();
   endtask

   task automatic test_compressed_lo();
      pc = 32'h100; comp = 1; nop = 0; eff = 32'hABCD4501; step();
      nchecks++; if (o_prev !== 1'b1) begin nerrors++; $display("FAIL lo_prev: got %b want 1", o_prev); end
      nchecks++; if (o_instr_buffer !== 32'hABCD4501) begin nerrors++; $display("FAIL lo_buffer: got %h want ABCD4501", o_instr_buffer); end
      // Compressed at hi: no capture, no spanning start.
      pc = 32'h102; eff = 32'h11112222; step();
      nchecks++; if ({o_prev, o_wait} !== 2'b00) begin nerrors++; $display("FAIL hi_comp prev/wait: got %b want 00", {o_prev, o_wait}); end
      nchecks++; if (o_instr_buffer !== 32'hABCD4501) begin nerrors++; $display("FAIL hi_comp_buffer: got %h want ABCD4501", o_instr_buffer); end
      // NOP suppresses the capture.
      pc = 32'h104; nop = 1; eff = 32'h33334444; step();
      nchecks++; if (o_prev !== 1'b0 || o_instr_buffer !== 32'hABCD4501) begin nerrors++; $display("FAIL nop_no_capture: got %b/%h want 0/ABCD4501", o_prev, o_instr_buffer); end
      nop = 0; eff = 32'h55556666; step();
      nchecks++; if (o_prev !== 1'b1 || o_instr_buffer !== 32'h55556666) begin nerrors++; $display("FAIL lo_recapture: got %b/%h want 1/55556666", o_prev, o_instr_buffer); end
   endtask

   task automatic test_stall_saved();
      // prev is 1 here; saved still holds its reset value.
      nchecks++; if (o_saved !== 1'b0) begin nerrors++; $display("FAIL saved_before_stall: got %b want 0", o_saved); end
      stall = 1; pc = 32'h102; comp = 0; nop = 0; eff = 32'hDEAD0000;
      for (int i = 0; i < 3; i++) begin
         step();
         nchecks++; if ({o_saved, o_stall_reg, o_prev, o_wait} !== 4'b1110) begin nerrors++; $display("FAIL stall_cycle%0d saved/stallreg/prev/wait: got %b want 1110", i, {o_saved, o_stall_reg, o_prev, o_wait}); end
      end
      stall = 0; pc = 32'h108; nop = 1; step();
      nchecks++; if ({o_saved, o_stall_reg, o_prev} !== 3'b100) begin nerrors++; $display("FAIL after_release saved/stallreg/prev: got %b want 100", {o_saved, o_stall_reg, o_prev}); end
   endtask

   task automatic test_spanning();
      pc = 32'h102; comp = 0; nop = 1; eff = 32'h05131234; instr = 32'hFFFFFFFF; step();
      nchecks++; if ({o_wait, o_inprog} !== 2'b10 || o_span_buf !== 16'h0513) begin nerrors++; $display("FAIL span_wait: got %b/%h want 10/0513", {o_wait, o_inprog}, o_span_buf); end
      // A non-compressed parcel at hi must not restart spanning outside IDLE.
      pc = 32'h106; eff = 32'hFFFF0000; instr = 32'h00A00000; step();
      nchecks++; if ({o_wait, o_inprog} !== 2'b01 || o_span_buf !== 16'h0513 || o_second !== 16'h0000) begin nerrors++; $display("FAIL span_ready: got %b/%h/%h want 01/0513/0000", {o_wait, o_inprog}, o_span_buf, o_second); end
      nchecks++; if (o_instr_buffer !== 32'h00A00000) begin nerrors++; $display("FAIL span_buffer_word: got %h want 00A00000", o_instr_buffer); end
      pc = 32'h104; nop = 0; eff = 32'h77778888; instr = 0; step();
`ifdef FROST_SPAN_HOLDOFF_EN
      nchecks++; if ({o_inprog, o_holdoff, o_use_buf} !== 3'b010) begin nerrors++; $display("FAIL span_holdoff: got %b want 010", {o_inprog, o_holdoff, o_use_buf}); end
      step();
`endif
      nchecks++; if ({o_inprog, o_holdoff, o_use_buf} !== 3'b001) begin nerrors++; $display("FAIL span_use_buffer: got %b want 001", {o_inprog, o_holdoff, o_use_buf}); end
      step();
      nchecks++; if ({o_wait, o_use_buf} !== 2'b00 || o_instr_buffer !== 32'h00A00000) begin nerrors++; $display("FAIL span_done: got %b/%h want 00/00A00000", {o_wait, o_use_buf}, o_instr_buffer); end
   endtask

   task automatic test_stall_mid_span();
      pc = 32'h10A; comp = 0; nop = 1; eff = 32'hC0DE0000; instr = 0; step();
      stall = 1; pc = 32'h10E; eff = 32'hBEEF0000; instr = 32'h1234ABCD;
      for (int i = 0; i < 2; i++) begin
         step();
         nchecks++; if ({o_wait, o_inprog, o_saved} !== 3'b100 || o_span_buf !== 16'hC0DE || o_second !== 16'h0000) begin nerrors++; $display("FAIL mid_stall%0d: got %b/%h/%h want 100/C0DE/0000", i, {o_wait, o_inprog, o_saved}, o_span_buf, o_second); end
      end
      stall = 0; instr = 32'h5678ABCD; step();
      nchecks++; if (o_inprog !== 1'b1 || o_second !== 16'hABCD || o_instr_buffer !== 32'h5678ABCD) begin nerrors++; $display("FAIL resume_ready: got %b/%h/%h want 1/ABCD/5678ABCD", o_inprog, o_second, o_instr_buffer); end
      pc = 32'h110; comp = 1; nop = 1; instr = 0; step();
`ifdef FROST_SPAN_HOLDOFF_EN
      step();
`endif
      nchecks++; if (o_use_buf !== 1'b1) begin nerrors++; $display("FAIL use_buf_set: got %b want 1", o_use_buf); end
      stall = 1; step();
      nchecks++; if (o_use_buf !== 1'b1) begin nerrors++; $display("FAIL use_buf_hold_stall: got %b want 1", o_use_buf); end
      stall = 0; step();
      nchecks++; if (o_use_buf !== 1'b0) begin nerrors++; $display("FAIL use_buf_clear: got %b want 0", o_use_buf); end
   endtask

   task automatic test_flush();
      pc = 32'h100; comp = 1; nop = 0; eff = 32'h99990001; step();
      stall = 1; step();
      stall = 0; pc = 32'h102; comp = 0; nop = 1; eff = 32'h0513AAAA; step();
      pc = 32'h106; instr = 32'h00A00000; step();
      nchecks++; if ({o_inprog, o_saved} !== 2'b11) begin nerrors++; $display("FAIL pre_flush ready/saved: got %b want 11", {o_inprog, o_saved}); end
      stall = 1; flush = 1; step();
      nchecks++; if (o_stall_reg !== 1'b1) begin nerrors++; $display("FAIL flush_stall_reg: got %b want 1", o_stall_reg); end
      nchecks++; if ({o_instr_buffer, o_prev, o_saved, o_wait, o_inprog, o_span_buf, o_second, o_holdoff, o_use_buf} !== '0) begin
         nerrors++; $display("FAIL flush_clear: buf=%h prev=%b saved=%b wait=%b ready=%b span=%h second=%h want all 0",
                             o_instr_buffer, o_prev, o_saved, o_wait, o_inprog, o_span_buf, o_second);
      end
      idle_inputs(); step();
      nchecks++; if ({o_stall_reg, o_wait, o_inprog} !== 3'b000) begin nerrors++; $display("FAIL post_flush: got %b want 000", {o_stall_reg, o_wait, o_inprog}); end
   endtask

   initial begin
      test_reset();
      test_compressed_lo();
      test_stall_saved();
      test_spanning();
      test_stall_mid_span();
      test_flush();
      $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
      $finish;
   end

endmodule
